output_deskew_buffer: RTL and testbench
=======================================

# output_deskew_buffer

Collects the two staggered column outputs of the leaky-ReLU stage (column 2 trails column 1 by one cycle when fed from the systolic array) and re-aligns them into complete two-element rows. Each column is held in its own small FIFO. A row is presented downstream with a valid/ready handshake only when both columns have data. The block sits directly downstream of the leaky-ReLU stage and feeds the unified-buffer write path.

## Interface
Parameters:
- DEPTH, 4: entries per column FIFO; power of two, ≥2.
- WIDTH, 16: data width, signed Q8.8; data is passed through bit-exact.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ob_valid_1_in  input  1  column-1 write strobe (driven by lr_valid_1_out).
- ob_valid_2_in  input  1  column-2 write strobe (driven by lr_valid_2_out).
- ob_data_1_in  input  WIDTH  column-1 data.
- ob_data_2_in  input  WIDTH  column-2 data.
- ob_flush_in  input  1  synchronous clear of both FIFOs.
- ob_ready_in  input  1  downstream ready to accept a row.
- ob_valid_out  output  1  complete row available.
- ob_data_1_out  output  WIDTH  row element from column 1.
- ob_data_2_out  output  WIDTH  row element from column 2.
- ob_count_out  output  $clog2(DEPTH)+1  complete rows held, equal to min(occ1, occ2).
- ob_overflow_out  output  1  sticky drop flag; present only with OB_OVERFLOW_EN.

## Operation
- Two independent FIFOs, each with a write pointer, a read pointer and an occupancy counter (0..DEPTH).
- Push n: occurs when ob_valid_n_in=1 and FIFO n is not full, or when FIFO n is full and a pop occurs in the same cycle.
- Pop: occurs when ob_valid_out=1 and ob_ready_in=1. Both FIFOs advance together.
- ob_valid_out = (occ1≠0) and (occ2≠0). Outputs are show-ahead: the data outputs show the FIFO heads.
- When ob_valid_out=0, both data outputs are forced to 0.
- Pointers wrap modulo DEPTH.
- Push while full with no pop: the write is dropped and the FIFO contents are unchanged.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged. This is legal at occupancy 0 only if a pop is impossible, so at empty only the push takes effect.
- Flush: ob_flush_in=1 zeroes all pointers and occupancies and clears the overflow flag. Flush has priority over push and pop in the same cycle; data presented in the flush cycle is discarded.
- No arithmetic is performed on the data; signed values pass through unmodified.

## Timing
- Reset (rst=0): outputs go to 0 immediately, without waiting for a clock. This covers ob_valid_out, both data outputs, ob_count_out and ob_overflow_out. All pointers and occupancies go to 0. The FIFO storage array need not be reset.
- Reset asserted mid-transfer loses all buffered rows. The first edge after rst returns to 1 behaves as from empty.
- Write latency: data pushed at edge N is visible at the head from edge N onward, i.e. in cycle N+1.
- Row latency: ob_valid_out rises one cycle after the later of the two column writes of that row. With the standard one-cycle stagger, that is two cycles after the column-1 write.
- Throughput: one row per cycle while ob_ready_in=1 and both columns keep up.
- ob_count_out and ob_valid_out are derived from registered state only. They have no combinational path from ob_ready_in.

## Configuration
- OB_OVERFLOW_EN defined:
  - ob_overflow_out exists.
  - It sets at the edge on which any column write is dropped.
  - It stays set until reset or flush.
- OB_OVERFLOW_EN undefined:
  - The port and its register are absent.
  - Dropped writes are silent; all other behaviour is identical.

## Test plan
- Stagger align: ready=1. Column 1 writes 0x0100 at cycle 0, column 2 writes 0xFF80 at cycle 1. Expect ob_valid_out=1 in cycle 2 only, with data (0x0100, 0xFF80), and ob_count_out back to 0 in cycle 3.
- Backpressure and wrap: ready=0, push 4 staggered rows (0x0001..0x0004 / 0x0011..0x0014). Expect ob_count_out=4. Then ready=1 drains the rows in order over 4 consecutive cycles. Repeat 3 times to exercise pointer wrap.
- Overflow: FIFOs full, ready=0, a 5th column-1 write of 0x7FFF. Expect the write dropped, ob_count_out=4 and ob_overflow_out=1. Then with ready=1, a same-cycle push of 0x1234 is accepted, count stays 4, and 0x1234 appears after the original 4 rows.
- Column imbalance: 3 column-1 writes and 1 column-2 write. Expect ob_count_out=1 and exactly one row popped. ob_valid_out then drops while column 1 still holds 2 entries.
- Flush: with 3 rows buffered and overflow set, pulse ob_flush_in together with a push and a pop. Next cycle expect ob_valid_out=0, count=0 and overflow=0. The pushed data must not appear later.
- Async reset: assert rst=0 between clock edges with 2 rows buffered. Expect all outputs 0 before the next edge. After release, a fresh staggered row is delivered per scenario 1.

Source files
------------

// File: rtl/output_deskew_buffer_if.sv
// Handshake/data bundle for output_deskew_buffer.
// The master side (leaky-ReLU stage and downstream consumer) drives the column
// strobes, column data, flush and ready; the slave side (the deskew buffer)
// drives the aligned row outputs.
// Optional feature macro: OB_OVERFLOW_EN adds the sticky ob_overflow_out flag.
interface output_deskew_buffer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                     ob_valid_1_in;
    logic                     ob_valid_2_in;
    logic [WIDTH-1:0]         ob_data_1_in;
    logic [WIDTH-1:0]         ob_data_2_in;
    logic                     ob_flush_in;
    logic                     ob_ready_in;
    logic                     ob_valid_out;
    logic [WIDTH-1:0]         ob_data_1_out;
    logic [WIDTH-1:0]         ob_data_2_out;
    logic [$clog2(DEPTH):0]   ob_count_out;
`ifdef OB_OVERFLOW_EN
    logic                     ob_overflow_out;
`endif

    modport master (
`ifdef OB_OVERFLOW_EN
        input  ob_overflow_out,
`endif
        output ob_valid_1_in,
        output ob_valid_2_in,
        output ob_data_1_in,
        output ob_data_2_in,
        output ob_flush_in,
        output ob_ready_in,
        input  ob_valid_out,
        input  ob_data_1_out,
        input  ob_data_2_out,
        input  ob_count_out
    );

    modport slave (
`ifdef OB_OVERFLOW_EN
        output ob_overflow_out,
`endif
        input  ob_valid_1_in,
        input  ob_valid_2_in,
        input  ob_data_1_in,
        input  ob_data_2_in,
        input  ob_flush_in,
        input  ob_ready_in,
        output ob_valid_out,
        output ob_data_1_out,
        output ob_data_2_out,
        output ob_count_out
    );
endinterface

// File: rtl/output_deskew_buffer.sv
// output_deskew_buffer
// Re-aligns the two staggered leaky-ReLU column outputs into complete
// two-element rows. Each column has its own small FIFO; a row is offered
// downstream (valid/ready, show-ahead) only when both columns hold data, and
// both FIFOs advance together on a pop. Data passes through bit-exact.
// Optional feature macro: OB_OVERFLOW_EN enables the sticky drop flag
// ob_overflow_out; without it, writes into a full column are silently dropped.
module output_deskew_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output_deskew_buffer_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem1 [DEPTH];
    logic [WIDTH-1:0] r_mem2 [DEPTH];
    logic [AW-1:0]    r_wr_ptr1;
    logic [AW-1:0]    r_rd_ptr1;
    logic [AW-1:0]    r_wr_ptr2;
    logic [AW-1:0]    r_rd_ptr2;
    logic [CW-1:0]    r_occ1;
    logic [CW-1:0]    r_occ2;

    logic             w_valid;
    logic             w_pop;
    logic             w_full1;
    logic             w_full2;
    logic             w_push1;
    logic             w_push2;

    // Row availability, pop and per-column push decisions from registered occupancy.
    always_comb begin
        w_valid = 1'b0;
        w_pop   = 1'b0;
        w_full1 = 1'b0;
        w_full2 = 1'b0;
        w_push1 = 1'b0;
        w_push2 = 1'b0;
        w_valid = (r_occ1 != '0) && (r_occ2 != '0);
        w_pop   = w_valid && bus.ob_ready_in;
        w_full1 = (r_occ1 == FULL_OCC);
        w_full2 = (r_occ2 == FULL_OCC);
        w_push1 = bus.ob_valid_1_in && (!w_full1 || w_pop);
        w_push2 = bus.ob_valid_2_in && (!w_full2 || w_pop);
    end

    // Column pointers and occupancies; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr1 <= '0;
            r_rd_ptr1 <= '0;
            r_wr_ptr2 <= '0;
            r_rd_ptr2 <= '0;
            r_occ1    <= '0;
            r_occ2    <= '0;
        end else if (bus.ob_flush_in) begin
            r_wr_ptr1 <= '0;
            r_rd_ptr1 <= '0;
            r_wr_ptr2 <= '0;
            r_rd_ptr2 <= '0;
            r_occ1    <= '0;
            r_occ2    <= '0;
        end else begin
            if (w_push1) begin
                r_wr_ptr1 <= r_wr_ptr1 + 1'b1;
            end
            if (w_push2) begin
                r_wr_ptr2 <= r_wr_ptr2 + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr1 <= r_rd_ptr1 + 1'b1;
                r_rd_ptr2 <= r_rd_ptr2 + 1'b1;
            end
            case ({w_push1, w_pop})
                2'b10:   r_occ1 <= r_occ1 + 1'b1;
                2'b01:   r_occ1 <= r_occ1 - 1'b1;
                default: r_occ1 <= r_occ1;
            endcase
            case ({w_push2, w_pop})
                2'b10:   r_occ2 <= r_occ2 + 1'b1;
                2'b01:   r_occ2 <= r_occ2 - 1'b1;
                default: r_occ2 <= r_occ2;
            endcase
        end
    end

    // Column storage; contents are don't-care until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (w_push1 && !bus.ob_flush_in) begin
            r_mem1[r_wr_ptr1] <= bus.ob_data_1_in;
        end
        if (w_push2 && !bus.ob_flush_in) begin
            r_mem2[r_wr_ptr2] <= bus.ob_data_2_in;
        end
    end

    assign bus.ob_valid_out  = w_valid;
    assign bus.ob_data_1_out = w_valid ? r_mem1[r_rd_ptr1] : '0;
    assign bus.ob_data_2_out = w_valid ? r_mem2[r_rd_ptr2] : '0;
    assign bus.ob_count_out  = (r_occ1 < r_occ2) ? r_occ1 : r_occ2;

`ifdef OB_OVERFLOW_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = (bus.ob_valid_1_in && w_full1 && !w_pop) ||
                    (bus.ob_valid_2_in && w_full2 && !w_pop);

    // Sticky drop flag, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (bus.ob_flush_in) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.ob_overflow_out = r_overflow;
`endif
endmodule

// File: tb/tb_output_deskew_buffer.sv
// Testbench for output_deskew_buffer.
// A queue-based column model forms expected rows into a scoreboard; a monitor
// on the falling edge compares valid/count/overflow and row data as the DUT
// presents them. Directed scenarios are followed by a randomized phase.
// Build with +define+OB_OVERFLOW_EN to also check the overflow flag.
module tb_output_deskew_buffer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] c1;
        logic [WIDTH-1:0] c2;
    } row_t;

    logic clk;
    logic rst;

    int assertCount;
    int failCount;

    logic [WIDTH-1:0] m1 [$];
    logic [WIDTH-1:0] m2 [$];
    row_t             sbQ [$];
    int               rowsHeld;
    logic             ovfModel;

    output_deskew_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    output_deskew_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v1, input logic [WIDTH-1:0] d1,
                                 input logic v2, input logic [WIDTH-1:0] d2,
                                 input logic fl, input logic rdy);
        bus.ob_valid_1_in = v1;
        bus.ob_data_1_in  = d1;
        bus.ob_valid_2_in = v2;
        bus.ob_data_2_in  = d2;
        bus.ob_flush_in   = fl;
        bus.ob_ready_in   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic fillRows(input logic [WIDTH-1:0] base1, input logic [WIDTH-1:0] base2);
        for (int i = 0; i <= 4; i++) begin
            applyStimulus(i < 4, WIDTH'(base1 + WIDTH'(i)), i > 0, WIDTH'(base2 + WIDTH'(i) - 1'b1), 1'b0, 1'b0);
        end
    endtask

    task automatic checkOverflow(input string name, input logic expected);
`ifdef OB_OVERFLOW_EN
        checkOutput(name, 32'(bus.ob_overflow_out), 32'(expected));
`endif
    endtask

    // Reference model: column queues pair up into complete rows in arrival order.
    always @(posedge clk or negedge rst) begin
        int  occ1;
        int  occ2;
        bit  pop;
        if (!rst) begin
            m1.delete();
            m2.delete();
            sbQ.delete();
            rowsHeld = 0;
            ovfModel = 1'b0;
        end else if (bus.ob_flush_in) begin
            m1.delete();
            m2.delete();
            sbQ.delete();
            rowsHeld = 0;
            ovfModel = 1'b0;
        end else begin
            pop  = (rowsHeld > 0) && bus.ob_ready_in;
            occ1 = m1.size() + rowsHeld;
            occ2 = m2.size() + rowsHeld;
            if ((bus.ob_valid_1_in && occ1 == DEPTH && !pop) ||
                (bus.ob_valid_2_in && occ2 == DEPTH && !pop)) begin
                ovfModel = 1'b1;
            end
            if (pop) begin
                rowsHeld--;
            end
            if (bus.ob_valid_1_in && (occ1 < DEPTH || pop)) begin
                m1.push_back(bus.ob_data_1_in);
            end
            if (bus.ob_valid_2_in && (occ2 < DEPTH || pop)) begin
                m2.push_back(bus.ob_data_2_in);
            end
            while (m1.size() > 0 && m2.size() > 0) begin
                row_t r;
                r.c1 = m1.pop_front();
                r.c2 = m2.pop_front();
                sbQ.push_back(r);
                rowsHeld++;
            end
        end
    end

    // Monitor: compare presented rows and status against the model mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("mon_valid", 32'(bus.ob_valid_out), 32'(rowsHeld > 0));
            checkOutput("mon_count", 32'(bus.ob_count_out), 32'(rowsHeld));
`ifdef OB_OVERFLOW_EN
            checkOutput("mon_overflow", 32'(bus.ob_overflow_out), 32'(ovfModel));
`endif
            if (bus.ob_valid_out) begin
                checkOutput("mon_row_expected", 32'(sbQ.size() != 0), 32'd1);
                if (sbQ.size() != 0) begin
                    checkOutput("mon_data1", 32'(bus.ob_data_1_out), 32'(sbQ[0].c1));
                    checkOutput("mon_data2", 32'(bus.ob_data_2_out), 32'(sbQ[0].c2));
                    if (bus.ob_ready_in) begin
                        void'(sbQ.pop_front());
                    end
                end
            end else begin
                checkOutput("mon_idle_data1", 32'(bus.ob_data_1_out), 32'd0);
                checkOutput("mon_idle_data2", 32'(bus.ob_data_2_out), 32'd0);
            end
        end
    end

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rowsHeld    = 0;
        ovfModel    = 1'b0;
        bus.ob_valid_1_in = 1'b0;
        bus.ob_valid_2_in = 1'b0;
        bus.ob_data_1_in  = '0;
        bus.ob_data_2_in  = '0;
        bus.ob_flush_in   = 1'b0;
        bus.ob_ready_in   = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(bus.ob_valid_out), 32'd0);
        checkOutput("reset_count", 32'(bus.ob_count_out), 32'd0);
        checkOutput("reset_data1", 32'(bus.ob_data_1_out), 32'd0);
        checkOutput("reset_data2", 32'(bus.ob_data_2_out), 32'd0);
        checkOverflow("reset_overflow", 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] stagger align");
        applyStimulus(1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s1_valid_c1", 32'(bus.ob_valid_out), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hFF80, 1'b0, 1'b1);
        checkOutput("s1_valid_c2", 32'(bus.ob_valid_out), 32'd1);
        checkOutput("s1_data1", 32'(bus.ob_data_1_out), 32'h0100);
        checkOutput("s1_data2", 32'(bus.ob_data_2_out), 32'hFF80);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s1_valid_c3", 32'(bus.ob_valid_out), 32'd0);
        checkOutput("s1_count_c3", 32'(bus.ob_count_out), 32'd0);

        $display("[TB] backpressure and wrap");
        for (int rep = 0; rep < 3; rep++) begin
            fillRows(16'h0001, 16'h0011);
            checkOutput("s2_count_full", 32'(bus.ob_count_out), 32'd4);
            checkOutput("s2_head_data1", 32'(bus.ob_data_1_out), 32'h0001);
            for (int k = 0; k < 4; k++) begin
                applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
            end
            checkOutput("s2_count_drained", 32'(bus.ob_count_out), 32'd0);
        end

        $display("[TB] overflow");
        fillRows(16'h0001, 16'h0011);
        applyStimulus(1'b1, 16'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s3_count_after_drop", 32'(bus.ob_count_out), 32'd4);
        checkOverflow("s3_overflow_set", 1'b1);
        applyStimulus(1'b1, 16'h1234, 1'b1, 16'h5678, 1'b0, 1'b1);
        checkOutput("s3_count_push_pop", 32'(bus.ob_count_out), 32'd4);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        checkOutput("s3_tail_data1", 32'(bus.ob_data_1_out), 32'h1234);
        checkOutput("s3_tail_data2", 32'(bus.ob_data_2_out), 32'h5678);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s3_valid_empty", 32'(bus.ob_valid_out), 32'd0);

        $display("[TB] column imbalance");
        applyStimulus(1'b1, 16'h0021, 1'b1, 16'h0031, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0022, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0023, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s4_count", 32'(bus.ob_count_out), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s4_valid_after_pop", 32'(bus.ob_valid_out), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

        $display("[TB] flush");
        fillRows(16'h0041, 16'h0051);
        applyStimulus(1'b1, 16'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s5_count_pre", 32'(bus.ob_count_out), 32'd3);
        applyStimulus(1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b1, 1'b1);
        checkOutput("s5_valid", 32'(bus.ob_valid_out), 32'd0);
        checkOutput("s5_count", 32'(bus.ob_count_out), 32'd0);
        checkOverflow("s5_overflow_clear", 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        checkOutput("s5_valid_later", 32'(bus.ob_valid_out), 32'd0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 16'h0061, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0062, 1'b1, 16'h0071, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0063, 1'b1, 16'h0072, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0064, 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0065, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s6_count_pre", 32'(bus.ob_count_out), 32'd2);
        checkOverflow("s6_overflow_pre", 1'b1);
        #2 rst = 1'b0;
        #1;
        checkOutput("s6_valid", 32'(bus.ob_valid_out), 32'd0);
        checkOutput("s6_count", 32'(bus.ob_count_out), 32'd0);
        checkOutput("s6_data1", 32'(bus.ob_data_1_out), 32'd0);
        checkOutput("s6_data2", 32'(bus.ob_data_2_out), 32'd0);
        checkOverflow("s6_overflow", 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hFF80, 1'b0, 1'b1);
        checkOutput("s6_row_valid", 32'(bus.ob_valid_out), 32'd1);
        checkOutput("s6_row_data1", 32'(bus.ob_data_1_out), 32'h0100);
        checkOutput("s6_row_data2", 32'(bus.ob_data_2_out), 32'hFF80);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s6_row_gone", 32'(bus.ob_valid_out), 32'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 99) < 60, WIDTH'($urandom),
                          $urandom_range(0, 99) < 60, WIDTH'($urandom),
                          $urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 55);
        end
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        checkOutput("final_rows_left", 32'(sbQ.size()), 32'(rowsHeld));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
